// File: rtl/sram_conf_loader_if.sv
// Command, write-data and read-data streams plus the SRAM port of the config loader.
// chksum is present only when SRAM_LDR_CHKSUM_EN is defined.
interface sram_conf_loader_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LEN_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wd_valid;
  logic              wd_ready;
  logic [31:0]       wd_data;
  logic [3:0]        wd_strb;
  logic              rd_valid;
  logic              rd_ready;
  logic [31:0]       rd_data;
  logic              sram_we;
  logic              sram_rd;
  logic [31:0]       sram_addr;
  logic [31:0]       sram_din;
  logic [3:0]        sram_str;
  logic [31:0]       sram_dout;
  logic              busy;
  logic              done;
`ifdef SRAM_LDR_CHKSUM_EN
  logic [31:0]       chksum;

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, wd_valid, wd_data, wd_strb, rd_ready, sram_dout,
    input  cmd_ready, wd_ready, rd_valid, rd_data, sram_we, sram_rd, sram_addr, sram_din, sram_str,
           busy, done, chksum
  );
  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wd_valid, wd_data, wd_strb, rd_ready, sram_dout,
    output cmd_ready, wd_ready, rd_valid, rd_data, sram_we, sram_rd, sram_addr, sram_din, sram_str,
           busy, done, chksum
  );
`else
  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, wd_valid, wd_data, wd_strb, rd_ready, sram_dout,
    input  cmd_ready, wd_ready, rd_valid, rd_data, sram_we, sram_rd, sram_addr, sram_din, sram_str,
           busy, done
  );
  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wd_valid, wd_data, wd_strb, rd_ready, sram_dout,
    output cmd_ready, wd_ready, rd_valid, rd_data, sram_we, sram_rd, sram_addr, sram_din, sram_str,
           busy, done
  );
`endif
endinterface

// File: rtl/sram_conf_loader.sv
// Burst initiator for one SRAM wrapper port: write bursts from a data stream, read bursts into a
// credit-managed FIFO. Optional running checksum output enabled by SRAM_LDR_CHKSUM_EN.
module sram_conf_loader #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_conf_loader_if.slave bus
);
  // One entry beyond RD_LAT+1 covers the registered sram_rd stage, so back-to-back reads fit.
  localparam int unsigned DEPTH = RD_LAT + 2;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned CR_W  = CNT_W + 2;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic [RD_LAT-1:0] rd_sh;
  logic [31:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic [CR_W-1:0]   inflight_c;
  logic [31:0]       head_nxt;
  logic              accept_c;
  logic              beat_c;
  logic              issue_c;
  logic              cap_c;
  logic              pop_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshakes, read credit and next state
  always_comb begin
    accept_c   = bus.cmd_valid && bus.cmd_ready && (state == S_IDLE);
    beat_c     = bus.wd_valid && bus.wd_ready && (state == S_WRITE);
    pop_c      = bus.rd_valid && bus.rd_ready;
    cap_c      = rd_sh[RD_LAT-1];
    inflight_c = CR_W'(bus.sram_rd);
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_c = inflight_c + CR_W'(rd_sh[i]);
    end
    issue_c    = (state == S_READ) && (remaining != '0) &&
                 ((CR_W'(count) + inflight_c) < (CR_W'(DEPTH) + CR_W'(pop_c)));
    count_nxt  = count + CNT_W'(cap_c) - CNT_W'(pop_c);
    rd_ptr_nxt = pop_c ? ptr_inc(rd_ptr) : rd_ptr;
    head_nxt   = (cap_c && (wr_ptr == rd_ptr_nxt)) ? bus.sram_dout : fifo_mem[rd_ptr_nxt];
    state_nxt  = state;
    case (state)
      S_IDLE: begin
        if (accept_c) begin
          if (bus.cmd_len == '0) state_nxt = S_DONE;
          else                   state_nxt = bus.cmd_wr ? S_WRITE : S_READ;
        end
      end
      S_WRITE: if (beat_c && (remaining == LEN_W'(1)))  state_nxt = S_DONE;
      S_READ:  if (issue_c && (remaining == LEN_W'(1))) state_nxt = S_DRAIN;
      S_DRAIN: if ((inflight_c == '0) && (count == '0)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Burst counters, SRAM strobes and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr          <= '0;
      remaining     <= '0;
      rd_sh         <= '0;
      bus.cmd_ready <= 1'b1;
      bus.wd_ready  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.sram_we   <= 1'b0;
      bus.sram_rd   <= 1'b0;
      bus.sram_addr <= '0;
      bus.sram_din  <= '0;
      bus.sram_str  <= '0;
    end else begin
      bus.cmd_ready <= (state == S_IDLE) && (state_nxt == S_IDLE);
      bus.wd_ready  <= (state_nxt == S_WRITE);
      bus.busy      <= (state_nxt != S_IDLE);
      bus.done      <= (state == S_DONE);
      bus.sram_we   <= beat_c;
      bus.sram_rd   <= issue_c;
      bus.sram_str  <= beat_c ? bus.wd_strb : 4'h0;
      if (beat_c)            bus.sram_din  <= bus.wd_data;
      if (beat_c || issue_c) bus.sram_addr <= 32'(addr);
      if (accept_c) begin
        addr      <= bus.cmd_addr;
        remaining <= bus.cmd_len;
      end else if (beat_c || issue_c) begin
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
      rd_sh[0] <= bus.sram_rd;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_sh[i] <= rd_sh[i-1];
      end
    end
  end

  // Read FIFO bookkeeping with a registered first-word fall-through head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      if (cap_c) wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      bus.rd_valid <= (count_nxt != '0);
      bus.rd_data  <= head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_c) fifo_mem[wr_ptr] <= bus.sram_dout;
  end

`ifdef SRAM_LDR_CHKSUM_EN
  // Sum of every word written or delivered since the last command accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        bus.chksum <= '0;
    else if (accept_c) bus.chksum <= '0;
    else               bus.chksum <= bus.chksum + (beat_c ? bus.wd_data : 32'h0)
                                                + (pop_c ? bus.rd_data : 32'h0);
  end
`endif

endmodule

// File: tb/tb_sram_conf_loader.sv
// Scoreboard bench for sram_conf_loader: stimulus queues expected SRAM writes and read words,
// a negedge monitor pops and compares them against the SRAM port and the read stream.
module tb_sram_conf_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_conf_loader_if #(.ADDR_W(12), .LEN_W(16)) bus ();
  sram_conf_loader #(.ADDR_W(12), .LEN_W(16), .RD_LAT(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  int          iss_cyc[$];
  int          pop_cyc[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_done = 0;
  int          cyc = 0;
  logic [31:0] mem [4096];
  logic [31:0] wdat [16];
  wr_t         mon_w;
  logic [31:0] mon_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Synchronous SRAM with one-cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.sram_we)
      for (int b = 0; b < 4; b++)
        if (bus.sram_str[b]) mem[bus.sram_addr[11:0]][8*b +: 8] <= bus.sram_din[8*b +: 8];
    if (bus.sram_rd) bus.sram_dout <= mem[bus.sram_addr[11:0]];
  end

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.sram_we || bus.sram_rd)
        check("we_rd_exclusive", 32'(bus.sram_we && bus.sram_rd), 32'd0);
      if (bus.sram_we) begin
        check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          mon_w = exp_wr.pop_front();
          check("wr_addr", bus.sram_addr, mon_w.addr);
          check("wr_data", bus.sram_din, mon_w.data);
          check("wr_strb", 32'(bus.sram_str), 32'(mon_w.strb));
        end
      end
      if (bus.sram_rd) iss_cyc.push_back(cyc);
      if (bus.rd_valid && bus.rd_ready) begin
        pop_cyc.push_back(cyc);
        check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
        if (exp_rd.size() != 0) begin
          mon_r = exp_rd.pop_front();
          check("rd_data", bus.rd_data, mon_r);
        end
      end
      if (bus.done) n_done++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [11:0] a, input logic [15:0] len);
    logic acc;
    int   guard;
    acc = 1'b0;
    guard = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = a;
    bus.cmd_len   = len;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = bus.cmd_ready;
      guard++;
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("cmd_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_done(input int mode);
    logic got;
    int   k;
    got = 1'b0;
    k = 0;
    while (!got && k < 500) begin
      bus.rd_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      @(negedge clk);
      got = bus.done;
      k++;
      tick();
    end
    bus.rd_ready = 1'b0;
    check("done_seen", 32'(got), 32'd1);
  endtask

  task automatic write_burst(input logic [11:0] a, input int n);
    logic [11:0] ea;
    logic        acc;
    int          guard;
    int          d0;
    for (int i = 0; i < n; i++) begin
      ea = a + 12'(i);
      exp_wr.push_back('{addr: 32'(ea), data: wdat[i], strb: 4'hF});
    end
    d0 = n_done;
    send_cmd(1'b1, a, 16'(n));
    for (int i = 0; i < n; i++) begin
      bus.wd_valid = 1'b1;
      bus.wd_data  = wdat[i];
      bus.wd_strb  = 4'hF;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 100) begin
        @(negedge clk);
        acc = bus.wd_ready;
        guard++;
        tick();
      end
      check("wd_accept", 32'(acc), 32'd1);
    end
    bus.wd_valid = 1'b0;
    wait_done(0);
    tick();
    tick();
    check("wr_done_once", 32'(n_done - d0), 32'd1);
  endtask

  task automatic read_burst(input logic [11:0] a, input int n, input int mode);
    for (int i = 0; i < n; i++) exp_rd.push_back(mem[12'(a + 12'(i))]);
    send_cmd(1'b0, a, 16'(n));
    wait_done(mode);
  endtask

  initial begin
    int i0;
    int p0;
    int d0;
    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wd_valid  = 1'b0;
    bus.wd_data   = '0;
    bus.wd_strb   = '0;
    bus.rd_ready  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_sram_we", 32'(bus.sram_we), 32'd0);
    check("rst_sram_rd", 32'(bus.sram_rd), 32'd0);
    check("rst_wd_ready", 32'(bus.wd_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: write 4 words at 0x010
    wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
    write_burst(12'h010, 4);

    // 2: read them back with rd_ready held high; expect back-to-back delivery
    exp_rd.push_back(32'h11); exp_rd.push_back(32'h22);
    exp_rd.push_back(32'h33); exp_rd.push_back(32'h44);
    p0 = pop_cyc.size();
    send_cmd(1'b0, 12'h010, 16'd4);
    wait_done(0);
    check("rd_pop_count", 32'(pop_cyc.size() - p0), 32'd4);
    if (pop_cyc.size() - p0 == 4) check("rd_back_to_back", 32'(pop_cyc[p0+3] - pop_cyc[p0]), 32'd3);
`ifdef SRAM_LDR_CHKSUM_EN
    check("chksum_rd", bus.chksum, 32'h000000AA);
`endif

    // 3: read 8 words with rd_ready high one cycle in three
    for (int i = 0; i < 8; i++) wdat[i] = 32'hC0DE0000 + 32'(i);
    write_burst(12'h100, 8);
    for (int i = 0; i < 8; i++) exp_rd.push_back(32'hC0DE0000 + 32'(i));
    i0 = iss_cyc.size();
    p0 = pop_cyc.size();
    send_cmd(1'b0, 12'h100, 16'd8);
    wait_done(1);
    check("slow_rd_issues", 32'(iss_cyc.size() - i0), 32'd8);
    check("slow_rd_pops", 32'(pop_cyc.size() - p0), 32'd8);
    if (iss_cyc.size() - i0 == 8) check("slow_rd_stalled", 32'((iss_cyc[i0+7] - iss_cyc[i0]) > 7), 32'd1);

    // 4: write crossing the top of the address space, then a zero-length command
    wdat[0] = 32'h5; wdat[1] = 32'h6; wdat[2] = 32'h7; wdat[3] = 32'h8;
    write_burst(12'hFFE, 4);
    read_burst(12'hFFF, 2, 0);
    d0 = n_done;
    send_cmd(1'b1, 12'h020, 16'd0);
    @(negedge clk);
    check("len0_done_c1", 32'(bus.done), 32'd0);
    check("len0_busy_c1", 32'(bus.busy), 32'd1);
    tick();
    @(negedge clk);
    check("len0_done_c2", 32'(bus.done), 32'd1);
    check("len0_cmd_ready_c2", 32'(bus.cmd_ready), 32'd0);
    tick();
    @(negedge clk);
    check("len0_cmd_ready_c3", 32'(bus.cmd_ready), 32'd1);
    check("len0_done_once", 32'(n_done - d0), 32'd1);
    tick();

    // 5: reset in the middle of a read burst with two reads in flight
    d0 = n_done;
    bus.rd_ready = 1'b0;
    send_cmd(1'b0, 12'h100, 16'd8);
    tick();
    tick();
    @(negedge clk);
    check("mid_rd_inflight", 32'(bus.sram_rd), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_sram_rd", 32'(bus.sram_rd), 32'd0);
    check("abort_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("post_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("post_rst_no_done", 32'(n_done - d0), 32'd0);
    tick();
    exp_rd.push_back(32'h11);
    exp_rd.push_back(32'h22);
    send_cmd(1'b0, 12'h010, 16'd2);
    wait_done(0);

`ifdef SRAM_LDR_CHKSUM_EN
    // 6: checksum wraps modulo 2^32
    wdat[0] = 32'hFFFFFFFF; wdat[1] = 32'h2;
    write_burst(12'h200, 2);
    check("chksum_wr", bus.chksum, 32'h00000001);
`endif

    tick();
    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
